// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, sampling constants and divider helper
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick, one pulse every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_baud_tick: DIV must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver, 16x oversampling, ready/ack hold with sticky error flags
module uart_rx #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PC_Uart_rxd,
    input  logic       rd_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    import uart_pkg::*;

    localparam int DIV = calc_div(CLK_HZ, BAUD);

    generate
        if (OVERSAMPLE != 16) begin : g_bad_os
            $error("uart_rx: only 16x oversampling is supported");
        end
    endgenerate

    logic       rxd_m;
    logic       rxd_s;
    logic       tick;
    rx_state_t  state;
    logic [3:0] scnt;
    logic [2:0] bidx;
    logic [7:0] shreg;
    logic       stop_sample;
    logic       deliver;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign stop_sample = tick && (state == STOP) && (scnt == LAST_SAMPLE);
    assign deliver     = stop_sample && rxd_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_m     <= 1'b1;
            rxd_s     <= 1'b1;
            state     <= IDLE;
            scnt      <= '0;
            bidx      <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_status <= 1'b0;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rxd_m     <= PC_Uart_rxd;
            rxd_s     <= rxd_m;
            rx_status <= 1'b0;

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rxd_s) begin
                            state <= START;
                            scnt  <= '0;
                        end
                    end
                    START: begin
                        // A start bit that is gone by mid-bit was line noise
                        if (scnt == MID_SAMPLE) begin
                            if (!rxd_s) begin
                                state <= DATA;
                                scnt  <= '0;
                                bidx  <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (scnt == LAST_SAMPLE) begin
                            shreg <= {rxd_s, shreg[7:1]};
                            scnt  <= '0;
                            if (bidx == 3'd7) state <= STOP;
                            else              bidx  <= bidx + 3'd1;
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                    STOP: begin
                        // Leave at mid-stop so a back-to-back start edge is not missed
                        if (scnt == LAST_SAMPLE) begin
                            state <= IDLE;
                            scnt  <= '0;
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (stop_sample && !rxd_s) frame_err <= 1'b1;

            if (deliver) begin
                rx_data   <= shreg;
                rx_status <= 1'b1;
                rx_ready  <= 1'b1;
                if (rx_ready && !rd_ack) overrun <= 1'b1;
            end else if (rd_ack) begin
                rx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       rd_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int status_cnt = 0;
    int status_cyc = 0;
    int cyc = 0;
    int s1;
    int snap;
    int lat;
    int lat_stim;

    uart_rx #(.CLK_HZ(640000), .BAUD(10000), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .PC_Uart_rxd (rxd),
        .rd_ack      (rd_ack),
        .err_clr     (err_clr),
        .rx_data     (rx_data),
        .rx_status   (rx_status),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rx_status) begin
            status_cnt = status_cnt + 1;
            status_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_data", rx_data, 8'h00);
        check("rst_status", rx_status, 1'b0);
        check("rst_ready", rx_ready, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // single good frame and its latency from the start edge
        s1 = cyc;
        snap = status_cnt;
        send_byte(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        lat = status_cyc - s1;
        check("a5_pulses", status_cnt - snap, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_ready", rx_ready, 1'b1);
        check("a5_ferr", frame_err, 1'b0);
        check("a5_ovr", overrun, 1'b0);
        check("a5_latency_ok", (lat >= 604 && lat <= 618), 1'b1);
        pulse_ack();
        check("a5_ack_ready", rx_ready, 1'b0);

        // short low glitch
        snap = status_cnt;
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_pulses", status_cnt - snap, 0);
        check("glitch_ready", rx_ready, 1'b0);
        check("glitch_ferr", frame_err, 1'b0);
        check("glitch_ovr", overrun, 1'b0);

        // framing error
        snap = status_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (100) @(negedge clk);
        check("fe_flag", frame_err, 1'b1);
        check("fe_pulses", status_cnt - snap, 0);
        check("fe_data_kept", rx_data, 8'hA5);
        check("fe_ready", rx_ready, 1'b0);
        pulse_clr();
        check("fe_cleared", frame_err, 1'b0);

        // back-to-back frames, no ack in between
        snap = status_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        check("b2b_pulses", status_cnt - snap, 2);
        check("b2b_ovr", overrun, 1'b1);
        check("b2b_data", rx_data, 8'h22);
        check("b2b_ready", rx_ready, 1'b1);
        pulse_ack();
        check("b2b_ack_ready", rx_ready, 1'b0);
        check("b2b_ovr_sticky", overrun, 1'b1);
        pulse_clr();
        check("b2b_ovr_cleared", overrun, 1'b0);

        // ack lands on the same cycle as the next delivery
        send_byte(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        check("pre55_ready", rx_ready, 1'b1);
        for (int k = 0; k < 4 && ((cyc % 4) != (s1 % 4)); k++) @(negedge clk);
        lat_stim = (lat < 1) ? 1 : ((lat > 700) ? 700 : lat);
        snap = status_cnt;
        fork
            send_byte(8'h55, 1'b1);
            begin
                repeat (lat_stim - 1) @(negedge clk);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("ack55_pulses", status_cnt - snap, 1);
        check("ack55_data", rx_data, 8'h55);
        check("ack55_ready", rx_ready, 1'b1);
        check("ack55_ovr", overrun, 1'b0);

        // reset during data bit 4, then a clean frame
        snap = status_cnt;
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (BIT_CLKS * 5 + 32) @(negedge clk);
                reset = 1'b0;
                #1;
                check("mrst_data", rx_data, 8'h00);
                check("mrst_ready", rx_ready, 1'b0);
                check("mrst_status", rx_status, 1'b0);
                check("mrst_ferr", frame_err, 1'b0);
                check("mrst_ovr", overrun, 1'b0);
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
        join
        repeat (50) @(negedge clk);
        check("mrst_no_partial", status_cnt - snap, 0);
        check("mrst_ready_after", rx_ready, 1'b0);
        send_byte(8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        check("ff_pulses", status_cnt - snap, 1);
        check("ff_data", rx_data, 8'hFF);
        check("ff_ready", rx_ready, 1'b1);
        check("ff_ferr", frame_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
